// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt arbiter and exception-entry sequencer: synchronizes hardware interrupt lines,
// arbitrates exception/eret/interrupt entry, then drives flush, PC redirect and a lockout window.
module cp0_int_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter int          FLUSH_CYCLES   = 1,
    parameter int          LOCKOUT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    output logic [5:0]  int_o,
    output logic        take_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] LOCK_LOAD  = (LOCKOUT_CYCLES > 0) ? 3'(LOCKOUT_CYCLES - 1) : 3'd0;

    logic [1:0]  state;
    logic [2:0]  count;
    logic [5:0]  sync_a;
    logic [5:0]  sync_b;
    logic [7:0]  pend;
    logic        int_ok;
    logic        accept;
    logic        take;
    logic [31:0] target;
    logic        unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 6'd0;
            sync_b <= 6'd0;
        end else begin
            sync_a <= hw_int_i;
            sync_b <= sync_a;
        end
    end

    // The timer is already in the clk domain, so it bypasses the synchronizer.
    assign int_o  = {sync_b[5] | timer_int_i, sync_b[4:0]};
    assign pend   = {int_o, cause_i[9:8]};
    assign int_ok = status_i[0] & ~status_i[1] & (|(pend & status_i[15:8]));

    always_comb begin
        accept = 1'b0;
        take   = 1'b0;
        target = EXC_VECTOR;
        if (state == ST_IDLE) begin
            if (exc_req_i) begin
                accept = 1'b1;
            end else if (eret_i) begin
                accept = 1'b1;
                target = epc_i;
            end else if (int_ok && inst_valid_i && !stall_i) begin
                accept = 1'b1;
                take   = 1'b1;
            end
        end
    end

    assign take_int_o = take;
    assign busy_o     = (state != ST_IDLE);

    // Flush length and lockout length are each counted down in the shared counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= 3'd0;
            flush_o  <= 1'b0;
            new_pc_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_FLUSH;
                        flush_o  <= 1'b1;
                        new_pc_o <= target;
                        count    <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (count == 3'd0) begin
                        flush_o <= 1'b0;
                        if (LOCKOUT_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_LOCK;
                            count <= LOCK_LOAD;
                        end
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                ST_LOCK: begin
                    if (count == 3'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    count   <= 3'd0;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
